bias_add_child: RTL

//  Per-column bias stage of the vector processing unit: adds a held bias to each signed 16-bit

---
 rtl/bias_add_child.sv | 112 +++++++++++
 1 files changed

// File: rtl/bias_add_child.sv
// Per-column bias stage: saturating signed add of a held bias, followed by a small
// ready/valid output FIFO and a sticky saturation flag for overflow monitoring.
module bias_add_child #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bias_load_in,
    input  logic [DATA_W-1:0] bias_in,
    input  logic              ba_valid_in,
    input  logic [DATA_W-1:0] ba_data_in,
    output logic              ba_ready_out,
    output logic              ba_valid_out,
    output logic [DATA_W-1:0] ba_data_out,
    input  logic              ba_ready_in,
    input  logic              sat_clr_in,
    output logic              sat_flag_out
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [DATA_W-1:0] SatMax = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0] SatMin = {1'b1, {(DATA_W - 1){1'b0}}};

    logic [DATA_W-1:0] bias_q, bias_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              sat_q, sat_d;

    logic              push, pop;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] sum_sat;
    logic              sat_hit;

    // Wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrOne;
    endfunction

    always_comb begin
        sum     = {ba_data_in[DATA_W-1], ba_data_in} + {bias_q[DATA_W-1], bias_q};
        // Sign bits disagree only when the true sum left the DATA_W range.
        sat_hit = sum[DATA_W] ^ sum[DATA_W-1];
        sum_sat = sum[DATA_W-1:0];
        if (sat_hit) begin
            sum_sat = sum[DATA_W] ? SatMin : SatMax;
        end
    end

    always_comb begin
        ba_ready_out = (count_q < CntFull);
        ba_valid_out = (count_q != '0);
        ba_data_out  = ba_valid_out ? mem_q[rd_ptr_q] : '0;
        sat_flag_out = sat_q;
    end

    always_comb begin
        push     = ba_valid_in && ba_ready_out;
        pop      = ba_valid_out && ba_ready_in;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
        // A saturating push in the same cycle as a clear keeps the flag set.
        if (push && sat_hit) begin
            sat_d = 1'b1;
        end else if (sat_clr_in) begin
            sat_d = 1'b0;
        end else begin
            sat_d = sat_q;
        end
        bias_d = bias_load_in ? bias_in : bias_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sat_q    <= 1'b0;
        end else begin
            bias_q   <= bias_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sat_q    <= sat_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= sum_sat;
        end
    end

endmodule
